// File: rtl/gemm_tile_scheduler.sv
// Output-stationary GEMM tile scheduler (mt, nt, kt loop) with a 1-cycle SRAM read pipe.
// Define GEMM_SCHED_PERF_EN to enable the saturating busy-cycle counter on perf_cycles_o.
module gemm_tile_scheduler #(
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     stall_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     pe_valid_o,
  output logic                     pe_init_save_o,
  output logic                     pe_acc_clr_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              perf_cycles_o
);

  localparam int PW = 2 * SizeAddrWidth + 1;
  localparam logic [SizeAddrWidth-1:0] One = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e state, state_nx;

  logic [SizeAddrWidth-1:0] mt_size, kt_size, nt_size;
  logic [SizeAddrWidth-1:0] mt, nt, kt;
  logic size_zero, accept, issue;
  logic kt_wrap, nt_wrap, last;
  logic rd_vld, rd_init, rd_last, we;
  logic [AddrWidth-1:0] rd_c, c_addr;

  assign size_zero = (M_size_i == '0) || (K_size_i == '0)
                  || (N_size_i == '0);
  assign accept  = (state == IDLE) && start_i;
  assign issue   = (state == RUN) && !stall_i;
  assign kt_wrap = (kt == kt_size - One);
  assign nt_wrap = (nt == nt_size - One);
  assign last    = kt_wrap && nt_wrap && (mt == mt_size - One);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_i) state_nx = size_zero ? DONE : RUN;
      RUN:     if (issue && last) state_nx = DRAIN;
      // final write is in flight when no further last-k read is queued
      DRAIN:   if (we && !rd_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mt_size <= '0;
      kt_size <= '0;
      nt_size <= '0;
      mt      <= '0;
      nt      <= '0;
      kt      <= '0;
    end else if (accept) begin
      mt_size <= M_size_i;
      kt_size <= K_size_i;
      nt_size <= N_size_i;
      mt      <= '0;
      nt      <= '0;
      kt      <= '0;
    end else if (issue) begin
      kt <= kt_wrap ? '0 : kt + One;
      if (kt_wrap) begin
        nt <= nt_wrap ? '0 : nt + One;
        if (nt_wrap) mt <= last ? '0 : mt + One;
      end
    end
  end

  assign sram_a_addr_o = AddrWidth'(PW'(mt) * PW'(kt_size) + PW'(kt));
  assign sram_b_addr_o = AddrWidth'(PW'(kt) * PW'(nt_size) + PW'(nt));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld  <= 1'b0;
      rd_init <= 1'b0;
      rd_last <= 1'b0;
      rd_c    <= '0;
      we      <= 1'b0;
      c_addr  <= '0;
    end else begin
      rd_vld  <= issue;
      rd_init <= issue && (kt == '0);
      rd_last <= issue && kt_wrap;
      if (issue) rd_c <= AddrWidth'(PW'(mt) * PW'(nt_size) + PW'(nt));
      we <= rd_last;
      if (rd_last) c_addr <= rd_c;
    end
  end

  assign pe_valid_o     = rd_vld;
  assign pe_init_save_o = rd_init;
  assign sram_c_we_o    = we;
  assign sram_c_addr_o  = c_addr;
  assign busy_o         = (state == RUN) || (state == DRAIN);
  assign done_o         = (state == DONE);
  assign pe_acc_clr_o   = (state == IDLE) || (state == DONE);

`ifdef GEMM_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        perf_q <= '0;
    else if (accept)                    perf_q <= '0;
    else if (busy_o && (perf_q != '1))  perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed scoreboard bench for gemm_tile_scheduler: reads and C writes
// are queued from a loop model and popped as the scheduler produces them.
module tb_gemm_tile_scheduler;

  localparam int SW = 8;
  localparam int AW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          stall_i = 1'b0;
  logic [SW-1:0] M_size_i = '0;
  logic [SW-1:0] K_size_i = '0;
  logic [SW-1:0] N_size_i = '0;
  logic [AW-1:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
  logic          sram_c_we_o, pe_valid_o, pe_init_save_o;
  logic          pe_acc_clr_o, busy_o, done_o;
  logic [31:0]   perf_cycles_o;

  gemm_tile_scheduler #(
    .SizeAddrWidth(SW),
    .AddrWidth(AW)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .start_i(start_i),
    .stall_i(stall_i),
    .M_size_i(M_size_i),
    .K_size_i(K_size_i),
    .N_size_i(N_size_i),
    .sram_a_addr_o(sram_a_addr_o),
    .sram_b_addr_o(sram_b_addr_o),
    .sram_c_addr_o(sram_c_addr_o),
    .sram_c_we_o(sram_c_we_o),
    .pe_valid_o(pe_valid_o),
    .pe_init_save_o(pe_init_save_o),
    .pe_acc_clr_o(pe_acc_clr_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .perf_cycles_o(perf_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic          init;
  } rd_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] c;
  } wr_t;

  rd_t rq[$];
  wr_t wq[$];
  rd_t re;
  wr_t we_e;

  int compared = 0;
  int mismatched = 0;
  int rel = 0;
  int done_cnt = 0;
  int done_rel = 0;
  int we_cnt = 0;
  logic [AW-1:0] prev_a = '0;
  logic [AW-1:0] prev_b = '0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int perf_exp(input int busy_cycles);
`ifdef GEMM_SCHED_PERF_EN
    return busy_cycles;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk_i) begin
    if (pe_valid_o) begin
      if (rq.size() == 0) begin
        check("rd_extra", 64'd1, 64'd0);
      end else begin
        re = rq.pop_front();
        check("a_addr", 64'(prev_a), 64'(re.a));
        check("b_addr", 64'(prev_b), 64'(re.b));
        check("init", 64'(pe_init_save_o), 64'(re.init));
      end
    end
    if (sram_c_we_o) begin
      we_cnt <= we_cnt + 1;
      if (wq.size() == 0) begin
        check("wr_extra", 64'd1, 64'd0);
      end else begin
        we_e = wq.pop_front();
        check("c_cyc", 64'(rel), 64'(we_e.cyc));
        check("c_addr", 64'(sram_c_addr_o), 64'(we_e.c));
      end
    end
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_rel <= rel;
      check("done_stat", 64'({busy_o, pe_acc_clr_o}), 64'(2'b01));
    end
    prev_a <= sram_a_addr_o;
    prev_b <= sram_b_addr_o;
  end

  // Loop-order model; stalled cycles issue nothing.
  task automatic push_job(input int m, input int k, input int n,
                          input int slo, input int shi,
                          output int exp_done);
    int c;
    c = 0;
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++)
        for (int ki = 0; ki < k; ki++) begin
          c++;
          while (c >= slo && c <= shi) c++;
          rq.push_back('{a: AW'(mi * k + ki), b: AW'(ki * n + ni),
                         init: (ki == 0)});
          if (ki == k - 1)
            wq.push_back('{cyc: c + 2, c: AW'(mi * n + ni)});
        end
    exp_done = (m * n * k == 0) ? -1 : c + 3;
  endtask

  task automatic run_job(input int m, input int k, input int n,
                         input int slo, input int shi, input int pulse,
                         input int exp_done, input int exp_perf);
    int d0;
    d0 = done_cnt;
    @(posedge clk_i); #1;
    rel = 0;
    M_size_i = SW'(m);
    K_size_i = SW'(k);
    N_size_i = SW'(n);
    start_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i); #1;
      rel++;
      start_i = (rel == pulse);
      stall_i = (rel >= slo) && (rel <= shi);
      M_size_i = SW'($urandom_range(0, 255));
      K_size_i = SW'($urandom_range(0, 255));
      N_size_i = SW'($urandom_range(0, 255));
      if (done_cnt != d0 && rel >= done_rel + 2) break;
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    check("done_pulse", 64'(done_cnt - d0), 64'd1);
    if (exp_done >= 0) check("done_cyc", 64'(done_rel), 64'(exp_done));
    check("rd_left", 64'(rq.size()), 64'd0);
    check("wr_left", 64'(wq.size()), 64'd0);
    check("perf", 64'(perf_cycles_o), 64'(perf_exp(exp_perf)));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a"}, 64'(sram_a_addr_o), 64'd0);
    check({tag, "_b"}, 64'(sram_b_addr_o), 64'd0);
    check({tag, "_c"}, 64'(sram_c_addr_o), 64'd0);
    check({tag, "_flags"},
          64'({sram_c_we_o, pe_valid_o, pe_init_save_o, busy_o, done_o}),
          64'd0);
    check({tag, "_clr"}, 64'(pe_acc_clr_o), 64'd1);
    check({tag, "_perf"}, 64'(perf_cycles_o), 64'd0);
  endtask

  initial begin
    int ed, d0, w0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_state("rst");
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    push_job(2, 2, 2, 0, -1, ed);
    run_job(2, 2, 2, 0, -1, -1, ed, ed - 1);

    push_job(1, 3, 1, 0, -1, ed);
    run_job(1, 3, 1, 0, -1, -1, ed, ed - 1);

    push_job(2, 2, 2, 3, 4, ed);
    run_job(2, 2, 2, 3, 4, -1, ed, ed - 1);

    push_job(2, 0, 2, 0, -1, ed);
    run_job(2, 0, 2, 0, -1, -1, ed, 0);
    check("zero_done_by2", 64'(done_rel >= 1 && done_rel <= 2), 64'd1);

    push_job(2, 2, 2, 0, -1, ed);
    run_job(2, 2, 2, 0, -1, 4, ed, ed - 1);

    push_job(2, 1, 3, 0, -1, ed);
    run_job(2, 1, 3, 0, -1, -1, ed, ed - 1);

    push_job(2, 3, 4, 5, 7, ed);
    run_job(2, 3, 4, 5, 7, -1, ed, ed - 1);

    push_job(2, 2, 2, 0, -1, ed);
    d0 = done_cnt;
    @(posedge clk_i); #1;
    rel = 0;
    M_size_i = 8'd2;
    K_size_i = 8'd2;
    N_size_i = 8'd2;
    start_i = 1'b1;
    repeat (5) begin
      @(posedge clk_i); #1;
      rel++;
      start_i = 1'b0;
    end
    rst_ni = 1'b0;
    #1;
    check_reset_state("midrst");
    rq.delete();
    wq.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    w0 = we_cnt;
    repeat (20) @(posedge clk_i);
    #1;
    check("rst_nodone", 64'(done_cnt - d0), 64'd0);
    check("rst_nowe", 64'(we_cnt - w0), 64'd0);
    check("rst_idle", 64'({busy_o, pe_acc_clr_o}), 64'(2'b01));

    push_job(2, 2, 2, 0, -1, ed);
    run_job(2, 2, 2, 0, -1, -1, ed, ed - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
